// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input.
// Latency: result published 2 cycles after the edge that first samples a new high.
// No backpressure: one valid strobe per complete PWM cycle; consumer must capture it.
module pwm_capture #(
    parameter int WIDTH = 20
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    // Saturation value of the period counter doubles as the timeout threshold.
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEAS = 1'b1
    } state_t;

    state_t           state_q;
    logic             s1_q;
    logic             s2_q;
    logic             s3_q;
    logic [WIDTH-1:0] per_cnt_q;
    logic [WIDTH-1:0] hi_cnt_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_time_q;
    logic             valid_q;
    logic             timeout_q;
    logic             level_q;

    logic             rise;
    logic             cnt_sat;
    logic [WIDTH-1:0] per_cnt_d;
    logic [WIDTH-1:0] hi_cnt_d;

    // s2 is the usable line level; s3 only exists to detect its rising edge.
    assign rise    = s2_q & ~s3_q;
    assign cnt_sat = (per_cnt_q == CNT_MAX);

    // Free-running increments; hi_cnt never exceeds per_cnt so it cannot wrap.
    always_comb begin
        per_cnt_d = per_cnt_q + CNT_ONE;
        hi_cnt_d  = hi_cnt_q;
        if (s2_q) begin
            hi_cnt_d = hi_cnt_q + CNT_ONE;
        end
    end

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Measurement FSM: counters, published results, strobe and timeout flags.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // First edge only arms: there is no complete cycle to report yet.
                    if (rise) begin
                        per_cnt_q <= CNT_ONE;
                        hi_cnt_q  <= CNT_ONE;
                        state_q   <= S_MEAS;
                    end else begin
                        per_cnt_q <= '0;
                        hi_cnt_q  <= '0;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        // Checked before saturation so a period of exactly CNT_MAX still reports.
                        period_q    <= per_cnt_q;
                        high_time_q <= hi_cnt_q;
                        valid_q     <= 1'b1;
                        timeout_q   <= 1'b0;
                        per_cnt_q   <= CNT_ONE;
                        hi_cnt_q    <= CNT_ONE;
                    end else if (cnt_sat) begin
                        // Line stuck: report which level, clear results and re-arm.
                        timeout_q   <= 1'b1;
                        level_q     <= s2_q;
                        period_q    <= '0;
                        high_time_q <= '0;
                        per_cnt_q   <= '0;
                        hi_cnt_q    <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        per_cnt_q <= per_cnt_d;
                        hi_cnt_q  <= hi_cnt_d;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    per_cnt_q <= '0;
                    hi_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture at WIDTH=8: table-driven PWM stream with a result scoreboard,
// followed by timeout, resume, asynchronous reset and stuck-high sequences.
module tb_pwm_capture;

    localparam int W   = 8;
    localparam int SAT = (1 << W) - 1;

    logic         clk_50 = 1'b0;
    logic         rst    = 1'b1;
    logic         pwm_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         level;

    always #5 clk_50 = ~clk_50;

    pwm_capture #(.WIDTH(W)) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .level     (level)
    );

    typedef struct {
        int p;
        int h;
        int edge_n;
    } exp_t;

    typedef struct {
        int h;
        int l;
        int n;
        int ep;
        int eh;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[6];

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int to_edge   = -1;
    int last_rise = 0;
    int prev_p    = 0;
    int prev_h    = 0;
    int vld_cnt   = 0;
    int vld_base  = 0;
    bit have_prev = 1'b0;

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic check(input string name, input integer act, input integer exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one high/low cycle and leaves the bench at a negedge.
    // The rise reports the previous cycle, due 2 edges after the edge sampling the high.
    task automatic drive_period(input int h, input int l, input int ep, input int eh);
        exp_t e;
        pwm_in    = 1'b1;
        last_rise = cyc + 1;
        if (have_prev) begin
            e.p      = prev_p;
            e.h      = prev_h;
            e.edge_n = cyc + 3;
            sb_q.push_back(e);
        end
        have_prev = 1'b1;
        prev_p    = ep;
        prev_h    = eh;
        repeat (h) @(negedge clk_50);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk_50);
    endtask

    // Output monitor: pops the scoreboard on every strobe and tracks timeout onset.
    initial begin
        exp_t e;
        bit prev_vld = 1'b0;
        bit prev_to  = 1'b0;
        forever begin
            @(posedge clk_50);
            #1;
            if (valid === 1'b1) begin
                vld_cnt++;
                check("valid_with_timeout", timeout, 0);
                if (prev_vld) check("valid_back_to_back", 1, 0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got valid=1 at edge %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("period", period, e.p);
                    check("high_time", high_time, e.h);
                    check("valid_edge", cyc, e.edge_n);
                end
            end
            if (timeout === 1'b1 && !prev_to) to_edge = cyc;
            prev_vld = (valid === 1'b1);
            prev_to  = (timeout === 1'b1);
        end
    end

    initial begin
        tbl[0] = '{h: 30, l: 70,  n: 5, ep: 100, eh: 30};
        tbl[1] = '{h: 80, l: 20,  n: 3, ep: 100, eh: 80};
        tbl[2] = '{h: 1,  l: 1,   n: 8, ep: 2,   eh: 1};
        tbl[3] = '{h: 5,  l: 250, n: 2, ep: 255, eh: 5};
        tbl[4] = '{h: 3,  l: 5,   n: 4, ep: 8,   eh: 3};
        tbl[5] = '{h: 10, l: 10,  n: 3, ep: 20,  eh: 10};

        // Reset state
        #3;
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_level", level, 0);
        repeat (3) @(negedge clk_50);
        rst = 1'b0;
        repeat (4) @(negedge clk_50);

        // Continuous stream through all table rows, including duty change and period=SAT
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                drive_period(tbl[r].h, tbl[r].l, tbl[r].ep, tbl[r].eh);
            end
        end
        check("no_timeout_at_max_period", to_edge, -1);

        // Line held low: timeout exactly SAT cycles after the last reload
        repeat (400) @(negedge clk_50);
        check("drain_stream", sb_q.size(), 0);
        check("low_timeout_edge", to_edge, last_rise + 2 + SAT);
        check("low_timeout", timeout, 1);
        check("low_level", level, 0);
        check("low_period", period, 0);
        check("low_high_time", high_time, 0);

        // Resume: first edge arms, second reports and clears timeout
        have_prev = 1'b0;
        vld_base  = vld_cnt;
        for (int k = 0; k < 3; k++) drive_period(10, 10, 20, 10);
        check("resume_timeout_clear", timeout, 0);
        check("resume_valid_count", vld_cnt - vld_base, 2);
        check("drain_resume", sb_q.size(), 0);

        // Asynchronous reset during the low phase of a cycle
        drive_period(30, 5, 100, 30);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_period", period, 0);
        check("mid_rst_high_time", high_time, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_level", level, 0);
        #1 rst = 1'b0;
        have_prev = 1'b0;
        repeat (65) @(negedge clk_50);
        vld_base = vld_cnt;
        for (int k = 0; k < 3; k++) drive_period(30, 70, 100, 30);
        check("post_rst_valid_count", vld_cnt - vld_base, 2);
        check("drain_post_rst", sb_q.size(), 0);

        // Stuck high after a single rising edge
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        have_prev = 1'b0;
        to_edge   = -1;
        vld_base  = vld_cnt;
        @(negedge clk_50);
        pwm_in    = 1'b1;
        last_rise = cyc + 1;
        repeat (400) @(negedge clk_50);
        check("high_timeout_edge", to_edge, last_rise + 2 + SAT);
        check("high_timeout", timeout, 1);
        check("high_level", level, 1);
        check("high_high_time", high_time, 0);
        check("high_period", period, 0);
        check("high_no_valid", vld_cnt - vld_base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform, such as the one driven by the team's buzzer PWM generator, and reports its period and high time in `clk_50` cycles. It sits on the receive side of a PWM link, for loop-back checking of generated tones or for reading PWM from external sensors. An unsynchronised `pwm_in` is sampled through a 2-FF synchroniser, and one result is published per complete PWM cycle. A timeout flags a stuck-high or stuck-low line.

## Interface
- `WIDTH`, default 20: width of the period and high-time counters and outputs. Maximum measurable period is 2^WIDTH-1 cycles, about 21 ms at 50 MHz.
- `clk_50`  in  1  system clock, 50 MHz; all logic on its rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `pwm_in`  in  1  PWM input; asynchronous to `clk_50`.
- `period`  out  WIDTH  last measured period in cycles; reset 0.
- `high_time`  out  WIDTH  last measured high time in cycles; reset 0.
- `valid`  out  1  single-cycle strobe: `period` and `high_time` were just updated; reset 0.
- `timeout`  out  1  sticky: no rising edge seen within 2^WIDTH-1 cycles; reset 0.
- `level`  out  1  synchronised line level latched at timeout; reset 0.

## Operation
- **Input conditioning**
  - Synchroniser chain `s1 <= pwm_in`, `s2 <= s1`, `s3 <= s2`.
  - `rise = s2 & ~s3`. Only `s2` is used as the line level.
- **Counters**
  - `per_cnt` and `hi_cnt` are WIDTH bits, internal, reset 0.
- **State machine:** states IDLE and MEAS; reset state IDLE.
  - IDLE:
    - Counters are held at 0.
    - On `rise`: `per_cnt <= 1`, `hi_cnt <= 1`, go to MEAS. No `valid`.
  - MEAS, on `rise`:
    - `period <= per_cnt`, `high_time <= hi_cnt`, `valid <= 1`, `timeout <= 0`.
    - Reload `per_cnt <= 1`, `hi_cnt <= 1`. Stay in MEAS.
  - MEAS, no `rise`, and `per_cnt != 2^WIDTH-1`:
    - `per_cnt++`.
    - `hi_cnt++` when `s2 == 1`.
  - MEAS, no `rise`, and `per_cnt == 2^WIDTH-1`:
    - `timeout <= 1`, `level <= s2`.
    - `period <= 0`, `high_time <= 0`.
    - Go to IDLE. No `valid`.
- **Result definition:** for a waveform high for H cycles and low for L cycles, every result after the first is `period = H+L` and `high_time = H`.
- **First edge:** the first rising edge after reset or after a timeout only arms the measurement. The first `valid` follows the second rising edge.
- **Simultaneous `rise` and saturation:** `rise` wins, so a normal result is published and no timeout occurs.
- **Constant low or constant high line:** `timeout` rises after 2^WIDTH-1 cycles in MEAS, and `level` reports the stuck value. In IDLE there is no timeout, so no edge is ever expected there.
- **Minimum resolvable waveform**
  - Pulses or gaps shorter than one clock may be lost by the synchroniser; this is accepted.
  - Minimum period is 2 cycles; minimum high time is 1 cycle.
- **Reset mid-measurement:** all outputs and counters clear immediately, the state returns to IDLE, and the in-flight cycle is discarded.

## Timing
- If `pwm_in` is first sampled high at edge k:
  - `rise` is true between edges k+1 and k+2.
  - At edge k+2, `period` and `high_time` update and `valid` goes high.
  - `valid` is high for exactly one cycle, after edge k+2 until edge k+3.
- `period` and `high_time` hold their values between `valid` strobes.
- `timeout` updates on the same edge as the saturation decision and stays high until the next `valid`, or until `rst`.
- `valid` and `timeout` are never both set on the same edge.
- No backpressure: a consumer must capture results on `valid`. At most one `valid` occurs per 2 cycles.

## Test plan
- Steady PWM at H=30, L=70 cycles, 5 periods, `pwm_in` changing half a cycle off the clock edge:
  - No `valid` on the first rising edge.
  - Then each strobe reports `period=100`, `high_time=30`.
  - `valid` occurs 2 edges after the edge that first samples the new high.
- Duty change mid-stream from H=30/L=70 to H=80/L=20:
  - The strobe after the change reports `period=100`, `high_time=80`.
  - No spurious extra `valid`.
- `WIDTH=8`, edges then `pwm_in` held low for 400 cycles:
  - `timeout=1`, `level=0` exactly 255 cycles after the last reload.
  - `period=0`, `high_time=0`.
  - Resuming H=10/L=10: two rising edges later, `valid` with `period=20`, `high_time=10`, and `timeout` clears.
- `WIDTH=8`, `pwm_in` stuck high after a rising edge:
  - `timeout=1`, `level=1`, `high_time=0`.
  - No `valid`.
- Fastest waveform H=1/L=1:
  - Every strobe reports `period=2`, `high_time=1`.
  - `valid` toggles 1,0,1,0.
- `rst` pulsed asynchronously, mid-cycle, between two rising edges:
  - All outputs read 0 immediately.
  - The next rising edge produces no `valid`.
  - The following edge produces correct values.
